t05_code_table_encoder: RTL and testbench
=========================================

# t05_code_table_encoder

Downstream consumer of the Huffman codebook synthesis stage. Captures each `(char_index, char_path, track_length)` record as the codebook walker reports a found character and stores it in a 256-entry code table. Once the codebook is complete, it accepts a byte stream and serializes each byte's Huffman code as a bit stream with valid/ready backpressure for the SPI/SRAM writer.

## Interface

**Parameters**
- `MAX_LEN`, default 128: width of `char_path`; maximum code length in bits.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `char_found` in 1: one-cycle strobe from codebook stage; record valid.
- `char_index` in 8: byte value whose code is reported.
- `char_path` in MAX_LEN: code bits; bit 0 is the root-most branch (0 = left, 1 = right).
- `track_length` in 7: number of valid bits in `char_path`.
- `cb_done` in 1: codebook complete (level, sampled every cycle).
- `in_valid` in 1: input byte valid.
- `in_char` in 8: input byte.
- `in_last` in 1: qualifies final byte of the message.
- `in_ready` out 1: encoder can accept a byte.
- `bit_valid` out 1: `bit_out` valid.
- `bit_out` out 1: current code bit.
- `bit_last` out 1: last bit of the current code.
- `bit_ready` in 1: downstream accepts the bit.
- `enc_done` out 1: message fully emitted (sticky).
- `err` out 1: byte with no table entry received (sticky).

## Operation

- **Table contents:** 256 entries of `{vld, len[6:0], path[MAX_LEN-1:0]}`. Every `vld` bit is cleared on `rst`.
- **LOAD** (state after reset):
  - `char_found`=1 writes entry `[char_index]` and sets `vld`.
  - A repeat index overwrites the earlier entry (last write wins).
  - `cb_done`=1 moves to READY. If `char_found` and `cb_done` are both high in the same cycle, the write is performed first.
- **READY:**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch the entry for `in_char` and `in_last`.
    - If `vld`=0 → ERR.
    - Otherwise → EMIT with bit pointer = 0.
  - `char_found` is ignored outside LOAD.
- **EMIT:**
  - `bit_valid`=1, `bit_out` = `path[ptr]`, `bit_last` = (`ptr` == `len`-1).
  - On `bit_valid & bit_ready`: `ptr` increments.
  - After the last bit transfers:
    - → DONE if the latched `in_last` is set,
    - otherwise → READY.
  - **Degenerate `len`=0** (single-leaf tree): emit exactly one bit, value 0, with `bit_last`=1.
- **DONE:** `enc_done`=1. No further handshakes; stays here until `rst`.
- **ERR:** `err`=1, `in_ready`=0, `bit_valid`=0. Stays here until `rst`.
- **Mid-operation reset:** `rst` in any state returns to LOAD and clears the table and all outputs. Any partially emitted code is abandoned.

## Timing

- **Reset values:**
  - `in_ready`=0, `bit_valid`=0, `bit_out`=0, `bit_last`=0, `enc_done`=0, `err`=0.
  - State = LOAD, `ptr`=0.
- **Table write:** the entry is readable from the cycle after `char_found`.
- **`in_ready` after `cb_done`:** `in_ready` rises 1 cycle after `cb_done` is sampled high.
- **Accept-to-first-bit latency:** 1 cycle. `bit_valid` rises the cycle after the byte handshake.
- **Throughput:** 1 bit per cycle while `bit_ready`=1. A code of length L takes L cycles (1 cycle for L=0). `in_ready` returns 1 cycle after the last bit transfers, so back-to-back bytes cost L+1 cycles each.
- **Backpressure:** while `bit_ready`=0, `bit_out`, `bit_last` and `bit_valid` hold stable.
- **`enc_done` / `err`:** each rises 1 cycle after its triggering event (last-bit transfer, or unknown-byte handshake).
- **`ptr` width:** 7 bits; `len` ≤ 127, so `ptr` never wraps.

## Configuration

- **`T05_ENC_BITCOUNT_EN`:**
  - **Defined:** adds output `bit_count` (out, 32 bits). It resets to 0 and increments on every `bit_valid & bit_ready`. It is frozen in DONE and ERR and is used by the header stage for the payload length field.
  - **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan

- **Load and encode:** load 'A'=`01` (len 2), 'B'=`1` (len 1), 'C'=`001` (len 3), then `cb_done`. Send "ABC" with `in_last` on 'C' and `bit_ready`=1 → bit stream 0,1,1,0,0,1; `bit_last` on bits 2, 3 and 6; `enc_done` 1 cycle after the final transfer. With the macro defined, `bit_count`=6.
- **Backpressure:** with 'C' loaded, hold `bit_ready`=0 for 5 cycles mid-code → `bit_out`/`bit_last` stable throughout; the stream is still 0,0,1 and no bits are lost or duplicated.
- **Unknown byte:** send 'Z' (never loaded) → `err`=1 the next cycle; `in_ready` and `bit_valid` stay 0 until `rst`.
- **Degenerate tree:** load 'C' with `track_length`=0 and send 'C' with `in_last` → exactly one bit (0, `bit_last`=1), then `enc_done`.
- **Overwrite and simultaneity:** write 'A'=`10` then 'A'=`011` (len 3), the second write in the same cycle as `cb_done` → encoding 'A' emits 0,1,1.
- **Reset mid-emit:** assert `rst` during the 2nd bit of a 3-bit code → all outputs 0 the next cycle and the table cleared. After reloading only 'B', sending 'A' sets `err`.

Source files
------------

// File: rtl/t05_code_table_encoder.sv
// t05_code_table_encoder
// Captures Huffman codebook records into a 256-entry code table. Once the
// codebook is complete, it serializes each input byte's code as a bit stream
// with valid/ready backpressure.
//
// Optional feature macro: T05_ENC_BITCOUNT_EN
//   When it is defined, the block adds the output bit_count. This is a 32-bit
//   count of transferred bits, and the header stage uses it for the payload
//   length field.
//
// Bit order: char_path[0] is the root-most branch. It is emitted first.
module t05_code_table_encoder #(
    parameter int MAX_LEN = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               char_found,
    input  logic [7:0]         char_index,
    input  logic [MAX_LEN-1:0] char_path,
    input  logic [6:0]         track_length,
    input  logic               cb_done,
    input  logic               in_valid,
    input  logic [7:0]         in_char,
    input  logic               in_last,
    output logic               in_ready,
    output logic               bit_valid,
    output logic               bit_out,
    output logic               bit_last,
    input  logic               bit_ready,
    output logic               enc_done,
`ifdef T05_ENC_BITCOUNT_EN
    output logic               err,
    output logic [31:0]        bit_count
`else
    output logic               err
`endif
);

    // Controller states. LOAD is entered on reset. DONE and ERR are terminal
    // until the next reset.
    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_READY = 3'd1,
        S_EMIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t r_state;

    // Code table. Path and length have no reset, because they are only
    // meaningful when the matching valid bit is set. Only the valid bits are
    // cleared on reset.
    logic [MAX_LEN-1:0] r_tab_path [256];
    logic [6:0]         r_tab_len  [256];
    logic [255:0]       r_tab_vld;

    // Entry latched for the byte that is currently being emitted
    logic [MAX_LEN-1:0] r_cur_path;
    logic [6:0]         r_cur_len;
    logic               r_cur_last;
    logic [6:0]         r_ptr;

    // Registered copies of the outputs
    logic               r_in_ready;
    logic               r_bit_valid;
    logic               r_bit_out;
    logic               r_bit_last;
    logic               r_enc_done;
    logic               r_err;

    // Combinational helpers
    logic               w_wr_en;
    logic               w_xfer;
    logic [MAX_LEN-1:0] w_sel_path;
    logic [6:0]         w_sel_len;
    logic               w_sel_vld;
    logic               w_first_bit;
    logic               w_first_last;
    logic [6:0]         w_ptr_nxt;
    logic [MAX_LEN-1:0] w_shift_path;
    logic               w_next_bit;
    logic               w_next_last;

    // A table write is only legal while loading. Records that arrive later
    // are ignored.
    assign w_wr_en = (r_state == S_LOAD) && char_found;

    // A bit moves downstream when the encoder offers a bit and the
    // consumer takes it
    assign w_xfer = (r_state == S_EMIT) && r_bit_valid && bit_ready;

    // Table lookup for the byte that is offered on the input port
    assign w_sel_path = r_tab_path[in_char];
    assign w_sel_len  = r_tab_len[in_char];
    assign w_sel_vld  = r_tab_vld[in_char];

    // A single-leaf tree has length 0. It still emits one bit, and that
    // bit is always 0.
    assign w_first_bit  = (w_sel_len == 7'd0) ? 1'b0 : w_sel_path[0];
    assign w_first_last = (w_sel_len <= 7'd1);

    // Next bit of the latched code. A shift is used instead of an index so
    // that any MAX_LEN works with the 7-bit pointer.
    assign w_ptr_nxt    = r_ptr + 7'd1;
    assign w_shift_path = r_cur_path >> w_ptr_nxt;
    assign w_next_bit   = w_shift_path[0];
    assign w_next_last  = (w_ptr_nxt == (r_cur_len - 7'd1));

    // Code table storage. Path and length are written while loading, and a
    // repeated index overwrites the earlier entry.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_tab_path[char_index] <= char_path;
            r_tab_len[char_index]  <= track_length;
        end
    end

    // Main controller. It owns the valid bits, the state, the pointer and
    // all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_tab_vld   <= 256'd0;
            r_cur_path  <= {MAX_LEN{1'b0}};
            r_cur_len   <= 7'd0;
            r_cur_last  <= 1'b0;
            r_ptr       <= 7'd0;
            r_in_ready  <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_last  <= 1'b0;
            r_enc_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    // The write lands in the same cycle that cb_done moves
                    // us on, so a simultaneous record is kept
                    if (w_wr_en) begin
                        r_tab_vld[char_index] <= 1'b1;
                    end
                    if (cb_done) begin
                        r_state    <= S_READY;
                        r_in_ready <= 1'b1;
                    end
                end

                S_READY: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_cur_path <= w_sel_path;
                        r_cur_len  <= w_sel_len;
                        r_cur_last <= in_last;
                        r_ptr      <= 7'd0;
                        if (!w_sel_vld) begin
                            // Unknown byte: the encoder stops until reset
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_EMIT;
                            r_bit_valid <= 1'b1;
                            r_bit_out   <= w_first_bit;
                            r_bit_last  <= w_first_last;
                        end
                    end
                end

                S_EMIT: begin
                    // Outputs change only on a transfer, which keeps them
                    // stable under backpressure
                    if (w_xfer) begin
                        if (r_bit_last) begin
                            r_bit_valid <= 1'b0;
                            r_bit_out   <= 1'b0;
                            r_bit_last  <= 1'b0;
                            r_ptr       <= 7'd0;
                            if (r_cur_last) begin
                                r_state    <= S_DONE;
                                r_enc_done <= 1'b1;
                            end else begin
                                r_state    <= S_READY;
                                r_in_ready <= 1'b1;
                            end
                        end else begin
                            r_ptr      <= w_ptr_nxt;
                            r_bit_out  <= w_next_bit;
                            r_bit_last <= w_next_last;
                        end
                    end
                end

                S_DONE: begin
                    r_in_ready  <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_enc_done  <= 1'b1;
                end

                S_ERR: begin
                    r_in_ready  <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_err       <= 1'b1;
                end

                default: begin
                    // An unreachable encoding falls back to a clean LOAD
                    // with no code table
                    r_state     <= S_LOAD;
                    r_tab_vld   <= 256'd0;
                    r_in_ready  <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_bit_out   <= 1'b0;
                    r_bit_last  <= 1'b0;
                    r_enc_done  <= 1'b0;
                    r_err       <= 1'b0;
                    r_ptr       <= 7'd0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign bit_valid = r_bit_valid;
    assign bit_out   = r_bit_out;
    assign bit_last  = r_bit_last;
    assign enc_done  = r_enc_done;
    assign err       = r_err;

`ifdef T05_ENC_BITCOUNT_EN
    logic [31:0] r_bit_count;

    // Payload length counter. Transfers only occur in EMIT, so the count is
    // frozen in DONE and ERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_count <= 32'd0;
        end else if (w_xfer) begin
            r_bit_count <= r_bit_count + 32'd1;
        end else begin
            r_bit_count <= r_bit_count;
        end
    end

    assign bit_count = r_bit_count;
`else
    // Without the counter, the payload length is derived downstream
`endif

endmodule

// File: tb/tb_t05_code_table_encoder.sv
// Directed bench for t05_code_table_encoder. Expected bits come from a bench
// model of the code table and are pushed to a scoreboard queue when a byte is
// driven. They are popped and compared on every bit transfer.
module tb_t05_code_table_encoder;

    localparam int MAX_LEN = 128;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               char_found = 1'b0;
    logic [7:0]         char_index = 8'd0;
    logic [MAX_LEN-1:0] char_path = {MAX_LEN{1'b0}};
    logic [6:0]         track_length = 7'd0;
    logic               cb_done = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_char = 8'd0;
    logic               in_last = 1'b0;
    logic               bit_ready = 1'b0;
    logic               in_ready;
    logic               bit_valid;
    logic               bit_out;
    logic               bit_last;
    logic               enc_done;
    logic               err;
`ifdef T05_ENC_BITCOUNT_EN
    logic [31:0]        bit_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries are {bit, last}
    logic [1:0]         exp_q [$];
    logic [MAX_LEN-1:0] m_path [256];
    logic [6:0]         m_len  [256];
    logic               m_vld  [256];

    t05_code_table_encoder #(.MAX_LEN(MAX_LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .char_found   (char_found),
        .char_index   (char_index),
        .char_path    (char_path),
        .track_length (track_length),
        .cb_done      (cb_done),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .bit_valid    (bit_valid),
        .bit_out      (bit_out),
        .bit_last     (bit_last),
        .bit_ready    (bit_ready),
        .enc_done     (enc_done),
`ifdef T05_ENC_BITCOUNT_EN
        .err          (err),
        .bit_count    (bit_count)
`else
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            m_vld[i]  = 1'b0;
            m_len[i]  = 7'd0;
            m_path[i] = {MAX_LEN{1'b0}};
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        exp_q.delete();
    endtask

    // One char_found record. upd_model is 0 when the DUT must ignore it.
    task automatic load_entry(input logic [7:0] idx, input logic [MAX_LEN-1:0] path,
                              input logic [6:0] len, input logic done, input logic upd_model);
        char_found   = 1'b1;
        char_index   = idx;
        char_path    = path;
        track_length = len;
        cb_done      = done;
        tick();
        char_found = 1'b0;
        cb_done    = 1'b0;
        if (upd_model) begin
            m_vld[idx]  = 1'b1;
            m_path[idx] = path;
            m_len[idx]  = len;
        end
    endtask

    task automatic finish_load();
        cb_done = 1'b1;
        tick();
        cb_done = 1'b0;
    endtask

    // Wait (bounded) for in_ready, queue the expected code, then do one handshake
    task automatic send_byte(input logic [7:0] ch, input logic last, output int waited);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_char  = ch;
        in_last  = last;
        if (m_vld[ch]) begin
            if (m_len[ch] == 7'd0) begin
                exp_q.push_back(2'b01);
            end else begin
                for (int i = 0; i < int'(m_len[ch]); i++) begin
                    exp_q.push_back({m_path[ch][i], (i == int'(m_len[ch]) - 1) ? 1'b1 : 1'b0});
                end
            end
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: every transfer pops one expected bit
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bit_valid === 1'b1 && bit_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    assert (bit_valid === 1'b0) else begin
                        n_errors++;
                        $error("FAIL extra_bit observed=%0b expected=none", bit_out);
                    end
                end else begin
                    e = exp_q.pop_front();
                    assert ({bit_out, bit_last} === e) else begin
                        n_errors++;
                        $error("FAIL bit_stream observed=%b%b expected=%b", bit_out, bit_last, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        model_clear();

        // Reset state
        do_reset();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("rst_bit_out",   {31'd0, bit_out},   32'd0);
        chk("rst_bit_last",  {31'd0, bit_last},  32'd0);
        chk("rst_enc_done",  {31'd0, enc_done},  32'd0);
        chk("rst_err",       {31'd0, err},       32'd0);
`ifdef T05_ENC_BITCOUNT_EN
        chk("rst_bit_count", bit_count, 32'd0);
`endif

        // Load and encode "ABC": A=01, B=1, C=001 in emission order
        bit_ready = 1'b1;
        load_entry(8'h41, 128'h2, 7'd2, 1'b0, 1'b1);
        load_entry(8'h42, 128'h1, 7'd1, 1'b0, 1'b1);
        load_entry(8'h43, 128'h4, 7'd3, 1'b0, 1'b1);
        chk("load_in_ready", {31'd0, in_ready}, 32'd0);
        finish_load();
        chk("cb_done_in_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h41, 1'b0, w);
        chk("first_bit_valid", {31'd0, bit_valid}, 32'd1);
        chk("first_bit_out",   {31'd0, bit_out},   32'd0);
        chk("emit_in_ready",   {31'd0, in_ready},  32'd0);
        send_byte(8'h42, 1'b0, w);
        chk("gap_after_A", w, 32'd2);
        send_byte(8'h43, 1'b1, w);
        chk("gap_after_B", w, 32'd1);
        tick();
        chk("enc_done_early1", {31'd0, enc_done}, 32'd0);
        tick();
        chk("C_last_bit", {31'd0, bit_last}, 32'd1);
        chk("enc_done_early2", {31'd0, enc_done}, 32'd0);
        tick();
        chk("enc_done_rise", {31'd0, enc_done}, 32'd1);
        chk("done_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("abc_drained", exp_q.size(), 32'd0);
`ifdef T05_ENC_BITCOUNT_EN
        chk("abc_bit_count", bit_count, 32'd6);
`endif
        // DONE accepts nothing further
        in_valid = 1'b1;
        in_char  = 8'h41;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_in_ready", {31'd0, in_ready},  32'd0);
            chk("done_sticky",   {31'd0, enc_done},  32'd1);
        end
        in_valid = 1'b0;

        // Backpressure on 'C' during its second bit
        do_reset();
        bit_ready = 1'b1;
        load_entry(8'h43, 128'h4, 7'd3, 1'b0, 1'b1);
        finish_load();
        send_byte(8'h43, 1'b1, w);
        tick();
        bit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, bit_valid}, 32'd1);
            chk("bp_out",   {31'd0, bit_out},   32'd0);
            chk("bp_last",  {31'd0, bit_last},  32'd0);
        end
        bit_ready = 1'b1;
        wait_drain();
        chk("bp_enc_done", {31'd0, enc_done}, 32'd1);
`ifdef T05_ENC_BITCOUNT_EN
        chk("bp_bit_count", bit_count, 32'd3);
`endif

        // Unknown byte; a record arriving in READY must be ignored
        do_reset();
        load_entry(8'h41, 128'h2, 7'd2, 1'b0, 1'b1);
        finish_load();
        load_entry(8'h5A, 128'h1, 7'd1, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0, w);
        chk("unk_err",       {31'd0, err},       32'd1);
        chk("unk_in_ready",  {31'd0, in_ready},  32'd0);
        chk("unk_bit_valid", {31'd0, bit_valid}, 32'd0);
        in_valid = 1'b1;
        in_char  = 8'h41;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_in_ready",  {31'd0, in_ready},  32'd0);
            chk("err_bit_valid", {31'd0, bit_valid}, 32'd0);
            chk("err_sticky",    {31'd0, err},       32'd1);
        end
        in_valid = 1'b0;
        do_reset();
        chk("err_cleared", {31'd0, err}, 32'd0);

        // Degenerate tree: len 0 emits a single 0 with bit_last
        load_entry(8'h43, 128'hF, 7'd0, 1'b0, 1'b1);
        finish_load();
        send_byte(8'h43, 1'b1, w);
        chk("deg_valid", {31'd0, bit_valid}, 32'd1);
        chk("deg_out",   {31'd0, bit_out},   32'd0);
        chk("deg_last",  {31'd0, bit_last},  32'd1);
        tick();
        chk("deg_enc_done", {31'd0, enc_done},  32'd1);
        chk("deg_one_bit",  {31'd0, bit_valid}, 32'd0);

        // Overwrite, with the second write in the same cycle as cb_done
        do_reset();
        load_entry(8'h41, 128'h1, 7'd2, 1'b0, 1'b1);
        load_entry(8'h41, 128'h6, 7'd3, 1'b1, 1'b1);
        chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h41, 1'b1, w);
        wait_drain();
        chk("ovr_enc_done", {31'd0, enc_done}, 32'd1);

        // Reset during the second bit of a 3-bit code
        do_reset();
        load_entry(8'h41, 128'h2, 7'd2, 1'b0, 1'b1);
        load_entry(8'h43, 128'h4, 7'd3, 1'b0, 1'b1);
        finish_load();
        send_byte(8'h43, 1'b0, w);
        tick();
        chk("mid_valid", {31'd0, bit_valid}, 32'd1);
        rst = 1'b1;
        bit_ready = 1'b0;
        tick();
        exp_q.delete();
        chk("mr_in_ready",  {31'd0, in_ready},  32'd0);
        chk("mr_bit_valid", {31'd0, bit_valid}, 32'd0);
        chk("mr_bit_out",   {31'd0, bit_out},   32'd0);
        chk("mr_bit_last",  {31'd0, bit_last},  32'd0);
        chk("mr_enc_done",  {31'd0, enc_done},  32'd0);
        chk("mr_err",       {31'd0, err},       32'd0);
        rst = 1'b0;
        model_clear();
        bit_ready = 1'b1;
        load_entry(8'h42, 128'h1, 7'd1, 1'b0, 1'b1);
        finish_load();
        send_byte(8'h41, 1'b0, w);
        chk("cleared_table_err", {31'd0, err},       32'd1);
        chk("cleared_no_bits",   {31'd0, bit_valid}, 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
